// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Shares the single register-file write port between NUM_REQ requesters
//   (ALU writeback, load unit, CSR unit, ...) with round-robin arbitration.
//   The accepted write is captured in an output stage and reaches the
//   register file on the following clock edge. Writes that target x0 are
//   accepted (the requester is released and the pointer advances) but
//   never raise rf_we.
//
// Parameters:
//   NUM_REQ  number of requesters, 2..4
//   XLEN     write data width
//   ADDR_W   register address width
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   stall      1 = no grant may be issued this cycle
//   req_valid  per-requester write request
//   req_addr   destination registers, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   write data, requester i at [i*XLEN +: XLEN]
//   req_ready  one-hot grant (combinational); handshake is valid & ready
//   rf_we      register-file write enable (registered)
//   rf_waddr   register-file write address (registered)
//   rf_wdata   register-file write data (registered)
//   grant_id   index of the requester whose write is being issued (registered)
//   busy       some requester is valid but not granted (combinational)
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*XLEN-1:0]   req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      rf_we,
   output logic [ADDR_W-1:0]         rf_waddr,
   output logic [XLEN-1:0]           rf_wdata,
   output logic [1:0]                grant_id,
   output logic                      busy
);

   // rr_ptr names the requester that currently has the highest priority.
   logic [1:0]        rr_ptr;
   logic [1:0]        next_ptr;
   logic [1:0]        win_id;
   logic              win_found;
   logic              grant;
   logic [ADDR_W-1:0] win_addr;
   logic [XLEN-1:0]   win_data;

   // Round-robin search: visit rr_ptr, rr_ptr+1, ... (mod NUM_REQ) and keep
   // the first valid requester encountered.
   always_comb begin : search
      int idx;
      // NOTE: every variable written in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      idx       = 0;
      win_found = 1'b0;
      win_id    = 2'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_id    = 2'(idx);
         end
      end
   end

   // A stall only suppresses new grants; the search result is unaffected.
   assign grant = win_found && !stall;

   // Pointer moves to the requester just after the winner.
   assign next_ptr = (win_id == 2'(NUM_REQ - 1)) ? 2'd0 : win_id + 2'd1;

   // One-hot ready plus the winner's address/data, built per requester so the
   // index never exceeds the vector range for any NUM_REQ.
   always_comb begin
      req_ready = '0;
      win_addr  = '0;
      win_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == 2'(i)) begin
            req_ready[i] = grant;
            win_addr     = req_addr[i*ADDR_W +: ADDR_W];
            win_data     = req_data[i*XLEN +: XLEN];
         end
      end
   end

   assign busy = |(req_valid & ~req_ready);

   // Output stage. Address, data and id only move on a grant so the register
   // file sees stable values between writes; rf_we is cleared whenever no
   // grant occurred, and a grant to x0 updates the stage without writing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= 2'd0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         grant_id <= 2'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         rf_we <= grant && (win_addr != '0);
         if (grant) begin
            rf_waddr <= win_addr;
            rf_wdata <= win_data;
            grant_id <= win_id;
            rr_ptr   <= next_ptr;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed bench for regfile_write_arbiter. Two instances are exercised:
// u_dut2 (NUM_REQ=2) and u_dut3 (NUM_REQ=3). A small round-robin model
// predicts req_ready/busy each cycle; every predicted grant pushes the
// expected output-stage contents to a scoreboard queue, which is popped and
// compared one clock later.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 5;

   typedef struct {
      logic             we;
      logic [ADDR_W-1:0] addr;
      logic [XLEN-1:0]   data;
      logic [1:0]        id;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // NUM_REQ = 2 instance
   logic                stall2 = 1'b0;
   logic [1:0]          valid2 = '0;
   logic [2*ADDR_W-1:0] addr2  = '0;
   logic [2*XLEN-1:0]   data2  = '0;
   logic [1:0]          ready2;
   logic                we2;
   logic [ADDR_W-1:0]   waddr2;
   logic [XLEN-1:0]     wdata2;
   logic [1:0]          gid2;
   logic                busy2;

   // NUM_REQ = 3 instance
   logic                stall3 = 1'b0;
   logic [2:0]          valid3 = '0;
   logic [3*ADDR_W-1:0] addr3  = '0;
   logic [3*XLEN-1:0]   data3  = '0;
   logic [2:0]          ready3;
   logic                we3;
   logic [ADDR_W-1:0]   waddr3;
   logic [XLEN-1:0]     wdata3;
   logic [1:0]          gid3;
   logic                busy3;

   regfile_write_arbiter #(.NUM_REQ(2), .XLEN(XLEN), .ADDR_W(ADDR_W)) u_dut2 (
      .clk(clk), .rst(rst), .stall(stall2),
      .req_valid(valid2), .req_addr(addr2), .req_data(data2),
      .req_ready(ready2), .rf_we(we2), .rf_waddr(waddr2), .rf_wdata(wdata2),
      .grant_id(gid2), .busy(busy2)
   );

   regfile_write_arbiter #(.NUM_REQ(3), .XLEN(XLEN), .ADDR_W(ADDR_W)) u_dut3 (
      .clk(clk), .rst(rst), .stall(stall3),
      .req_valid(valid3), .req_addr(addr3), .req_data(data3),
      .req_ready(ready3), .rf_we(we3), .rf_waddr(waddr3), .rf_wdata(wdata3),
      .grant_id(gid3), .busy(busy3)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   // Stimulus operands per requester and model state per instance size.
   logic [ADDR_W-1:0] ta [4];
   logic [XLEN-1:0]   td [4];
   int                mptr  [4];
   logic [ADDR_W-1:0] laddr [4];
   logic [XLEN-1:0]   ldata [4];
   logic [1:0]        lid   [4];
   exp_t              sb [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
      ta[i] = a;
      td[i] = d;
   endtask

   task automatic model_reset();
      for (int n = 0; n < 4; n++) begin
         mptr[n]  = 0;
         laddr[n] = '0;
         ldata[n] = '0;
         lid[n]   = 2'd0;
      end
      sb.delete();
   endtask

   // One clock cycle on instance n: drive, check combinational outputs,
   // clock, then check the output stage against the scoreboard.
   task automatic step(input string tag, input int n, input logic st, input logic [3:0] v);
      bit         found;
      int         w;
      int         idx;
      logic [3:0] exp_ready;
      logic [3:0] vmask;
      logic       exp_busy;
      logic [3:0] obs_ready;
      logic       obs_busy;
      exp_t       e;

      // drive
      if (n == 2) begin
         stall2 = st;
         valid2 = v[1:0];
         for (int i = 0; i < 2; i++) begin
            addr2[i*ADDR_W +: ADDR_W] = ta[i];
            data2[i*XLEN +: XLEN]     = td[i];
         end
      end else begin
         stall3 = st;
         valid3 = v[2:0];
         for (int i = 0; i < 3; i++) begin
            addr3[i*ADDR_W +: ADDR_W] = ta[i];
            data3[i*XLEN +: XLEN]     = td[i];
         end
      end
      #1;

      // model: round-robin winner from the model pointer
      found = 0;
      w     = 0;
      for (int k = 0; k < n; k++) begin
         idx = (mptr[n] + k) % n;
         if (!found && v[idx]) begin
            found = 1;
            w     = idx;
         end
      end
      vmask     = 4'((1 << n) - 1);
      exp_ready = (found && !st) ? 4'(1 << w) : 4'd0;
      exp_busy  = |(v & vmask & ~exp_ready);

      obs_ready = (n == 2) ? {2'b00, ready2} : {1'b0, ready3};
      obs_busy  = (n == 2) ? busy2 : busy3;
      check({tag, ".ready"}, 64'(obs_ready), 64'(exp_ready));
      check({tag, ".busy"},  64'(obs_busy),  64'(exp_busy));

      if (found && !st) begin
         e.we   = (ta[w] != '0);
         e.addr = ta[w];
         e.data = td[w];
         e.id   = 2'(w);
         sb.push_back(e);
         mptr[n] = (w + 1) % n;
      end

      @(posedge clk);
      #1;

      if (sb.size() > 0) begin
         e = sb.pop_front();
         laddr[n] = e.addr;
         ldata[n] = e.data;
         lid[n]   = e.id;
      end else begin
         e.we   = 1'b0;
         e.addr = laddr[n];
         e.data = ldata[n];
         e.id   = lid[n];
      end
      if (n == 2) begin
         check({tag, ".rf_we"},    64'(we2),    64'(e.we));
         check({tag, ".rf_waddr"}, 64'(waddr2), 64'(e.addr));
         check({tag, ".rf_wdata"}, 64'(wdata2), 64'(e.data));
         check({tag, ".grant_id"}, 64'(gid2),   64'(e.id));
      end else begin
         check({tag, ".rf_we"},    64'(we3),    64'(e.we));
         check({tag, ".rf_waddr"}, 64'(waddr3), 64'(e.addr));
         check({tag, ".rf_wdata"}, 64'(wdata3), 64'(e.data));
         check({tag, ".grant_id"}, 64'(gid3),   64'(e.id));
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ".we2"},    64'(we2),    64'd0);
      check({tag, ".waddr2"}, 64'(waddr2), 64'd0);
      check({tag, ".wdata2"}, 64'(wdata2), 64'd0);
      check({tag, ".gid2"},   64'(gid2),   64'd0);
      check({tag, ".we3"},    64'(we3),    64'd0);
      check({tag, ".gid3"},   64'(gid3),   64'd0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) set_req(i, '0, '0);
      model_reset();

      // Power-on reset
      #3;
      check_outputs_zero("por");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Two requesters saturating: strict alternation 0,1,0,1
      set_req(0, 5'd3, 32'hDEADBEEF);
      set_req(1, 5'd7, 32'h12345678);
      for (int c = 0; c < 4; c++) step("sat2", 2, 1'b0, 4'b0011);
      check("sat2.last_we_high", 64'(we2), 64'd1);

      // Asynchronous reset mid-run: outputs clear before any clock edge
      valid2 = '0;
      rst    = 1'b1;
      #1;
      check_outputs_zero("midrst");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step("post_rst", 2, 1'b0, 4'b0011);   // pointer back at 0: req0 wins

      // Write to x0 from req1 alone: granted, no write, pointer advances
      set_req(1, 5'd0, 32'hFFFFFFFF);
      step("x0", 2, 1'b0, 4'b0010);
      set_req(1, 5'd7, 32'h12345678);
      step("after_x0", 2, 1'b0, 4'b0011);   // req0 first

      // Stall with both valid: no grants, busy, pointer frozen
      for (int c = 0; c < 3; c++) step("stall", 2, 1'b1, 4'b0011);
      step("unstall", 2, 1'b0, 4'b0011);    // req1 (pointer was 1)

      // Stall arriving just after a grant does not cancel the staged write
      set_req(0, 5'd5, 32'hA5A5A5A5);
      step("pre_stall", 2, 1'b0, 4'b0001);
      step("stall_staged", 2, 1'b1, 4'b0011);
      step("idle2", 2, 1'b0, 4'b0000);

      // Three requesters saturating: 0,1,2,0,1,2
      set_req(0, 5'd1, 32'h00000011);
      set_req(1, 5'd2, 32'h00000022);
      set_req(2, 5'd31, 32'h00000033);
      for (int c = 0; c < 6; c++) step("sat3", 3, 1'b0, 4'b0111);
      // req1 withdraws before its turn: order 0 then 2
      step("skip_a", 3, 1'b0, 4'b0111);
      step("skip_b", 3, 1'b0, 4'b0101);
      // Single requester held valid: one write per cycle
      for (int c = 0; c < 3; c++) step("single", 3, 1'b0, 4'b0100);
      step("idle3", 3, 1'b0, 4'b0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
